barry_motion: RTL and testbench
===============================

# barry_motion

Frame-synchronous motion controller for Barry, the jetpack player sprite. It integrates thrust and gravity once per video frame and clamps the result to the playfield ceiling and floor. It drives the sprite bounding box and jetpack-flame flag consumed by the pixel colouring stage. Outputs change only at frame start, so coordinates stay stable for the whole active scan.

## Interface
- X_POS, 10'd100, fixed left edge of Barry (barry_x0)
- WIDTH, 10'd30, sprite width; barry_x1 = X_POS + WIDTH
- HEIGHT, 9'd60, sprite height; barry_y1 = barry_y0 + HEIGHT
- Y_TOP, 9'd0, minimum barry_y0
- Y_FLOOR, 9'd479, maximum barry_y1
- GRAVITY, 1, downward velocity increment per update
- THRUST, 2, upward velocity increment per update while thrusting
- VMAX, 8, velocity magnitude limit in either direction
- TICK_DIV, 1, number of frame_start events per physics update (1..15)
- clk  in  1  pixel/system clock
- reset  in  1  synchronous, active-high; clock clk
- frame_start  in  1  start-of-vertical-blank indication; may be held high for several cycles
- thrust  in  1  jetpack button, already synchronised to clk
- freeze  in  1  game-over hold; suppresses motion
- barry_x0 / barry_x1  out  10 each  horizontal bounds (constant)
- barry_y0 / barry_y1  out  9 each  vertical bounds
- on  out  1  flame visible for the current frame
- state  out  2  motion state (GROUNDED, FLYING, FALLING, CEILING)

## Operation
- Tick generation: a rising edge of frame_start (0→1, registered compare) counts one frame. An update event fires on every TICK_DIV-th frame. The divider resets to 0.
- Velocity v is signed 6-bit; positive means downward. At an update, thrust is sampled on the edge cycle:
  - thrust=1: v = max(v − THRUST, −VMAX)
  - thrust=0: v = min(v + GRAVITY, VMAX)
- Position arithmetic is done in 11-bit signed to prevent wrap. y_new = barry_y0 + v.
  - If y_new < Y_TOP: barry_y0 = Y_TOP, v = 0, state CEILING.
  - Else if y_new + HEIGHT > Y_FLOOR: barry_y0 = Y_FLOOR − HEIGHT, v = 0, state GROUNDED.
  - Else barry_y0 = y_new. State is FLYING if v<0, FALLING if v>0. If v==0, state is FLYING when thrust=1, else FALLING.
- The on output takes the sampled thrust value at each update and holds it until the next update.
- freeze=1 at an update: position, v and state are held, and on is forced to 0. The divider keeps counting.
- Reset values:
  - barry_y0 = Y_FLOOR − HEIGHT (419), barry_y1 = 479
  - barry_x0 = 100, barry_x1 = 130
  - v = 0, state GROUNDED, on = 0, divider = 0, edge register = 0

## Timing
- Latency: outputs update on the clock edge one cycle after the cycle in which the frame_start rising edge is detected. Otherwise they are constant.
- frame_start held high for N cycles produces exactly one frame count.
- reset coinciding with frame_start: reset wins, and no update occurs.
- reset mid-frame: reset values appear on the next clock edge. The first update after reset occurs on the TICK_DIV-th subsequent edge.
- barry_y0 and barry_y1 always change on the same clock edge; no intermediate value is ever visible.

## Configuration
- PHYS_SUBPIXEL_EN defined:
  - Position and v carry 4 extra fractional LSBs.
  - GRAVITY, THRUST and VMAX are in 1/16-pixel units, and v widens to 10 bits.
  - barry_y0 is the truncated integer part; clamping uses the integer part, and the fraction is zeroed on clamp.
  - Reset position is integer-exact.
- Not defined: all quantities are whole pixels, as described above.

## Structure
- Shared package barry_pkg holds:
  - the motion_state_t enum (GROUNDED=0, FLYING=1, FALLING=2, CEILING=3)
  - coordinate width constants (X_W=10, Y_W=9)
  - default geometry constants, which the colouring stage also imports
- Sub-module frame_tick: frame_start edge detector plus TICK_DIV divider. Outputs a one-cycle update pulse.

## Test plan
- Reset, then idle: barry_y0=419, barry_y1=479, barry_x0=100, barry_x1=130, state=GROUNDED, on=0. Ten gravity-only frames leave all values unchanged.
- Thrust held from ground for 5 frames: barry_y0 = 417, 413, 407, 399, 391; v saturates at −8; on=1; state=FLYING.
- Thrust held until ceiling: barry_y0 clamps to 0, state=CEILING, v=0. Each further frame gives v=−2, then clamps again, so barry_y0 stays 0.
- Release thrust at v=−8, barry_y0=200: barry_y0 = 193, 187, 182, …; state FLYING while v<0, then FALLING. on=0 from the first released frame.
- Falling with v=8 from barry_y0=415: next update gives barry_y0=419, v=0, state=GROUNDED. The following thrust frame gives barry_y0=417.
- frame_start held 3 cycles → one update only. freeze=1 → outputs frozen and on=0. TICK_DIV=2 → position changes on every second frame_start only.

Source files
------------

// File: rtl/barry_pkg.sv
// barry_pkg: shared motion-state enum, coordinate widths and default sprite geometry
package barry_pkg;
  typedef enum logic [1:0] {GROUNDED = 2'd0, FLYING = 2'd1, FALLING = 2'd2, CEILING = 2'd3} motion_state_t;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam logic [X_W-1:0] X_POS_D = 10'd100;
  localparam logic [X_W-1:0] WIDTH_D = 10'd30;
  localparam logic [Y_W-1:0] HEIGHT_D = 9'd60;
  localparam logic [Y_W-1:0] Y_TOP_D = 9'd0;
  localparam logic [Y_W-1:0] Y_FLOOR_D = 9'd479;
  localparam int GRAVITY_D = 1;
  localparam int THRUST_D = 2;
  localparam int VMAX_D = 8;
  localparam int TICK_DIV_D = 1;
endpackage

// File: rtl/barry_motion_if.sv
// barry_motion_if: frame/button inputs and sprite bounding-box outputs of the motion controller
interface barry_motion_if;
  import barry_pkg::*;
  logic frame_start;
  logic thrust;
  logic freeze;
  logic [X_W-1:0] barry_x0;
  logic [X_W-1:0] barry_x1;
  logic [Y_W-1:0] barry_y0;
  logic [Y_W-1:0] barry_y1;
  logic on;
  motion_state_t state;
  modport master (output frame_start, thrust, freeze, input barry_x0, barry_x1, barry_y0, barry_y1, on, state);
  modport slave (input frame_start, thrust, freeze, output barry_x0, barry_x1, barry_y0, barry_y1, on, state);
endinterface

// File: rtl/barry_motion_frame_tick.sv
// barry_motion_frame_tick: frame_start rising-edge detector and TICK_DIV divider, one-cycle update pulse
module barry_motion_frame_tick #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  output logic upd
);
  logic fs_q;
  logic [3:0] cnt;
  logic rise;
  logic last;
  always_comb begin
    rise = frame_start & ~fs_q;
    last = cnt == 4'(TICK_DIV - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_q <= 1'b0;
      cnt <= '0;
      upd <= 1'b0;
    end else begin
      fs_q <= frame_start;
      upd <= rise & last;
      if (rise) cnt <= last ? 4'd0 : cnt + 4'd1;
    end
  end
endmodule

// File: rtl/barry_motion.sv
// barry_motion: per-frame thrust/gravity integration with ceiling/floor clamp for the Barry sprite
// PHYS_SUBPIXEL_EN adds 4 fractional bits to position and velocity (velocity widens to 10 bits).
module barry_motion
  import barry_pkg::*;
#(
  parameter logic [X_W-1:0] X_POS = X_POS_D,
  parameter logic [X_W-1:0] WIDTH = WIDTH_D,
  parameter logic [Y_W-1:0] HEIGHT = HEIGHT_D,
  parameter logic [Y_W-1:0] Y_TOP = Y_TOP_D,
  parameter logic [Y_W-1:0] Y_FLOOR = Y_FLOOR_D,
  parameter int GRAVITY = GRAVITY_D,
  parameter int THRUST = THRUST_D,
  parameter int VMAX = VMAX_D,
  parameter int TICK_DIV = TICK_DIV_D
) (
  input logic clk,
  input logic reset,
  barry_motion_if.slave bus
);
`ifdef PHYS_SUBPIXEL_EN
  localparam int FRAC = 4;
  localparam int VW = 10;
`else
  localparam int FRAC = 0;
  localparam int VW = 6;
`endif
  localparam int PW = Y_W + FRAC;
  localparam int AW = 11 + FRAC;
  localparam logic [Y_W-1:0] FLR = Y_FLOOR - HEIGHT;
  localparam logic signed [AW-1:0] LIM = AW'(VMAX);
  localparam logic signed [AW-1:0] TOP_S = $signed(AW'(Y_TOP));
  localparam logic signed [AW-1:0] FLR_S = $signed(AW'(FLR));
  logic [PW-1:0] p, pn;
  logic signed [VW-1:0] v, vn;
  logic signed [AW-1:0] vt, vl, yn, yi;
  motion_state_t st, sn;
  logic on_q, thr_q, frz_q, upd, ceil, gnd;
  barry_motion_frame_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .frame_start(bus.frame_start),
    .upd(upd)
  );
  // thr_q/frz_q hold the values seen on the edge cycle, which is when upd is being registered
  always_comb begin
    vt = thr_q ? AW'(v) - AW'(THRUST) : AW'(v) + AW'(GRAVITY);
    vl = thr_q ? (vt < -LIM ? -LIM : vt) : (vt > LIM ? LIM : vt);
    yn = $signed(AW'(p)) + vl;
    yi = yn >>> FRAC;
    ceil = yi < TOP_S;
    gnd = !ceil && yi > FLR_S;
    pn = ceil ? PW'(Y_TOP) << FRAC : gnd ? PW'(FLR) << FRAC : PW'(yn);
    vn = (ceil || gnd) ? '0 : VW'(vl);
    sn = ceil ? CEILING : gnd ? GROUNDED : (vl < 0 || (vl == 0 && thr_q)) ? FLYING : FALLING;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      p <= PW'(FLR) << FRAC;
      v <= '0;
      st <= GROUNDED;
      on_q <= 1'b0;
      thr_q <= 1'b0;
      frz_q <= 1'b0;
    end else begin
      thr_q <= bus.thrust;
      frz_q <= bus.freeze;
      if (upd) begin
        on_q <= thr_q & ~frz_q;
        if (!frz_q) begin
          p <= pn;
          v <= vn;
          st <= sn;
        end
      end
    end
  end
  always_comb begin
    bus.barry_x0 = X_POS;
    bus.barry_x1 = X_POS + WIDTH;
    bus.barry_y0 = Y_W'(p >> FRAC);
    bus.barry_y1 = Y_W'(p >> FRAC) + HEIGHT;
    bus.on = on_q;
    bus.state = st;
  end
endmodule

// File: tb/tb_barry_motion.sv
// tb_barry_motion: scoreboard bench for barry_motion, plus a TICK_DIV=2 instance for divider checks
module tb_barry_motion;
  typedef struct {
    logic [8:0] y0;
    logic [8:0] y1;
    logic [1:0] st;
    logic on;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fs = 1'b0;
  logic thr = 1'b0;
  logic frz = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int my, mv;
  logic [1:0] ms;
  logic mon;
  exp_t q[$];
  barry_motion_if a ();
  barry_motion_if b ();
  assign a.frame_start = fs;
  assign a.thrust = thr;
  assign a.freeze = frz;
  assign b.frame_start = fs;
  assign b.thrust = thr;
  assign b.freeze = frz;
  barry_motion dut (.clk(clk), .reset(reset), .bus(a));
  barry_motion #(.TICK_DIV(2)) dut2 (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  task automatic model(input logic t, input logic f);
    int nv, y;
    if (!f) begin
      nv = t ? mv - 2 : mv + 1;
      if (nv < -8) nv = -8;
      if (nv > 8) nv = 8;
      y = my + nv;
      if (y < 0) begin my = 0; mv = 0; ms = 2'd3; end
      else if (y + 60 > 479) begin my = 419; mv = 0; ms = 2'd0; end
      else begin my = y; mv = nv; ms = (nv < 0 || (nv == 0 && t)) ? 2'd1 : 2'd2; end
    end
    mon = t & ~f;
    q.push_back('{9'(my), 9'(my + 60), ms, mon});
  endtask
  task automatic do_frame(input logic t, input logic f, input int hold);
    exp_t e;
    @(negedge clk);
    thr = t; frz = f; fs = 1'b1;
    model(t, f);
    repeat (hold) @(negedge clk);
    fs = 1'b0;
    repeat (3) @(negedge clk);
    e = q.pop_front();
    n_chk++;
    if ({a.barry_y0, a.barry_y1, a.state, a.on} !== {e.y0, e.y1, e.st, e.on}) begin
      n_fail++;
      $display("FAIL frame: got y0=%0d y1=%0d st=%0d on=%b, expected y0=%0d y1=%0d st=%0d on=%b",
               a.barry_y0, a.barry_y1, a.state, a.on, e.y0, e.y1, e.st, e.on);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; fs = 1'b0; thr = 1'b0; frz = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    my = 419; mv = 0; ms = 2'd0; mon = 1'b0;
    q.delete();
  endtask
  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({a.barry_y0, a.barry_y1, a.barry_x0, a.barry_x1, a.state, a.on} !== {9'd419, 9'd479, 10'd100, 10'd130, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got y0=%0d y1=%0d x0=%0d x1=%0d st=%0d on=%b, expected 419 479 100 130 0 0",
               a.barry_y0, a.barry_y1, a.barry_x0, a.barry_x1, a.state, a.on);
    end
    for (int i = 0; i < 10; i++) do_frame(1'b0, 1'b0, 1);
    n_chk++;
    if (a.barry_y0 !== 9'd419 || a.state !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_ground: got y0=%0d st=%0d, expected 419 0", a.barry_y0, a.state);
    end
  endtask
  task automatic test_thrust();
    logic [8:0] ey[5] = '{9'd417, 9'd413, 9'd407, 9'd399, 9'd391};
    logic [8:0] ey2[5] = '{9'd419, 9'd417, 9'd417, 9'd413, 9'd413};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_frame(1'b1, 1'b0, 1);
      n_chk++;
      if (a.barry_y0 !== ey[i] || a.state !== 2'd1 || a.on !== 1'b1) begin
        n_fail++;
        $display("FAIL thrust_%0d: got y0=%0d st=%0d on=%b, expected y0=%0d st=1 on=1", i, a.barry_y0, a.state, a.on, ey[i]);
      end
      n_chk++;
      if (b.barry_y0 !== ey2[i]) begin
        n_fail++;
        $display("FAIL tick_div2_%0d: got y0=%0d, expected %0d", i, b.barry_y0, ey2[i]);
      end
    end
  endtask
  task automatic test_release();
    logic [8:0] ey[3] = '{9'd384, 9'd378, 9'd373};
    for (int i = 0; i < 8; i++) begin
      do_frame(1'b0, 1'b0, 1);
      n_chk++;
      if (a.on !== 1'b0 || a.state !== (i < 7 ? 2'd1 : 2'd2) || (i < 3 && a.barry_y0 !== ey[i])) begin
        n_fail++;
        $display("FAIL release_%0d: got y0=%0d st=%0d on=%b", i, a.barry_y0, a.state, a.on);
      end
    end
  endtask
  task automatic test_floor();
    int i;
    for (i = 0; i < 60 && a.state !== 2'd0; i++) do_frame(1'b0, 1'b0, 1);
    n_chk++;
    if (a.barry_y0 !== 9'd419 || a.state !== 2'd0) begin
      n_fail++;
      $display("FAIL landing: got y0=%0d st=%0d after %0d frames, expected 419 0", a.barry_y0, a.state, i);
    end
    do_frame(1'b1, 1'b0, 1);
    n_chk++;
    if (a.barry_y0 !== 9'd417) begin
      n_fail++;
      $display("FAIL takeoff: got y0=%0d, expected 417", a.barry_y0);
    end
  endtask
  task automatic test_ceiling();
    int i;
    for (i = 0; i < 80 && a.barry_y0 !== 9'd0; i++) do_frame(1'b1, 1'b0, 1);
    n_chk++;
    if (a.barry_y0 !== 9'd0 || a.barry_y1 !== 9'd60 || a.state !== 2'd3) begin
      n_fail++;
      $display("FAIL ceiling: got y0=%0d y1=%0d st=%0d after %0d frames, expected 0 60 3", a.barry_y0, a.barry_y1, a.state, i);
    end
    for (int k = 0; k < 2; k++) begin
      do_frame(1'b1, 1'b0, 1);
      n_chk++;
      if (a.barry_y0 !== 9'd0 || a.state !== 2'd3) begin
        n_fail++;
        $display("FAIL ceiling_hold_%0d: got y0=%0d st=%0d, expected 0 3", k, a.barry_y0, a.state);
      end
    end
  endtask
  task automatic test_hold();
    logic [8:0] y;
    do_frame(1'b0, 1'b0, 1);
    do_frame(1'b0, 1'b0, 1);
    y = a.barry_y0;
    do_frame(1'b0, 1'b0, 3);
    n_chk++;
    if (a.barry_y0 !== y + 9'd3) begin
      n_fail++;
      $display("FAIL held_frame_start: got y0=%0d, expected %0d", a.barry_y0, y + 9'd3);
    end
  endtask
  task automatic test_freeze();
    logic [8:0] y;
    logic [1:0] s;
    do_frame(1'b1, 1'b0, 1);
    y = a.barry_y0;
    s = a.state;
    for (int i = 0; i < 3; i++) begin
      do_frame(1'b1, 1'b1, 1);
      n_chk++;
      if (a.barry_y0 !== y || a.state !== s || a.on !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_%0d: got y0=%0d st=%0d on=%b, expected y0=%0d st=%0d on=0", i, a.barry_y0, a.state, a.on, y, s);
      end
    end
    do_frame(1'b1, 1'b0, 1);
  endtask
  task automatic test_latency();
    logic [8:0] y;
    exp_t e;
    y = a.barry_y0;
    @(negedge clk);
    thr = 1'b1; frz = 1'b0; fs = 1'b1;
    model(1'b1, 1'b0);
    @(negedge clk);
    fs = 1'b0;
    n_chk++;
    if (a.barry_y0 !== y) begin
      n_fail++;
      $display("FAIL latency_early: got y0=%0d one cycle after edge, expected %0d", a.barry_y0, y);
    end
    @(negedge clk);
    e = q.pop_front();
    n_chk++;
    if (a.barry_y0 !== e.y0 || a.barry_y1 !== e.y1) begin
      n_fail++;
      $display("FAIL latency_update: got y0=%0d y1=%0d, expected %0d %0d", a.barry_y0, a.barry_y1, e.y0, e.y1);
    end
  endtask
  task automatic test_reset_frame();
    do_reset();
    @(negedge clk);
    thr = 1'b1; reset = 1'b1; fs = 1'b1;
    @(negedge clk);
    reset = 1'b0; fs = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (a.barry_y0 !== 9'd419 || a.on !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_with_frame: got y0=%0d on=%b, expected 419 0", a.barry_y0, a.on);
    end
    do_frame(1'b1, 1'b0, 1);
    do_frame(1'b1, 1'b0, 1);
    @(negedge clk);
    fs = 1'b1;
    @(negedge clk);
    reset = 1'b1; fs = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    my = 419; mv = 0; ms = 2'd0; mon = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    n_chk++;
    if (a.barry_y0 !== 9'd419 || a.state !== 2'd0 || a.on !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got y0=%0d st=%0d on=%b, expected 419 0 0", a.barry_y0, a.state, a.on);
    end
    do_frame(1'b1, 1'b0, 1);
    n_chk++;
    if (b.barry_y0 !== 9'd419) begin
      n_fail++;
      $display("FAIL div2_first_after_reset: got y0=%0d, expected 419", b.barry_y0);
    end
    do_frame(1'b1, 1'b0, 1);
    n_chk++;
    if (b.barry_y0 !== 9'd417) begin
      n_fail++;
      $display("FAIL div2_second_after_reset: got y0=%0d, expected 417", b.barry_y0);
    end
  endtask
  initial begin
    test_reset();
    test_thrust();
    test_release();
    test_floor();
    test_ceiling();
    test_hold();
    test_freeze();
    test_latency();
    test_reset_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
